axi_user_cmd_seq: RTL and testbench

AXI_USER_CMD_SEQ -- requirements
Module: axi_user_cmd_seq

---
 rtl/axi_user_seq_pkg.sv | 31 +++
 rtl/axi_user_seq_wfifo.sv | 69 ++++++
 rtl/axi_user_cmd_seq.sv | 188 ++++++++++++++++++
 tb/tb_axi_user_cmd_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_user_seq_pkg.sv
// Shared types and widths for the AXI user-command sequencer.
package axi_user_seq_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;
  localparam int LEN_W      = 4;
  localparam int STRB_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_WBURST,
    ST_RBURST,
    ST_DRAIN
  } seq_state_e;

  // Latched command; the address is held at the default width.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [LEN_W-1:0]      len;
    logic                  w_r;
    logic [STRB_W-1:0]     strb;
  } cmd_t;

  // Number of beats in a burst described by a len field (len + 1).
  function automatic logic [LEN_W:0] beats_of(input logic [LEN_W-1:0] len);
    return {1'b0, len} + (LEN_W+1)'(1);
  endfunction

endpackage

// File: rtl/axi_user_seq_wfifo.sv
// Write-data buffer: synchronous first-word-fall-through FIFO with occupancy count.
module axi_user_seq_wfifo #(
  parameter int  DEPTH  = 16,
  parameter int  DATA_W = 64,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointer and occupancy; simultaneous push and pop leave the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axi_user_cmd_seq.sv
// Sequences buffered commands into the AXI burst master's user interface.
//
//   state     | meaning
//   ST_IDLE   | accepting a command (cmd_ready high)
//   ST_WAIT   | command latched; waiting for master free and enough write data
//   ST_ISSUE  | user_start pulse, one cycle
//   ST_WBURST | popping one write beat per falling edge of the write stall
//   ST_RBURST | forwarding read beats from the master to rdat
//   ST_DRAIN  | burst done; waiting for master free, then sampling status
module axi_user_cmd_seq
  import axi_user_seq_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WFIFO_DEPTH = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_w_r,
  input  logic [STRB_W-1:0] cmd_strb,
  input  logic              wdat_valid,
  output logic              wdat_ready,
  input  logic [DATA_W-1:0] wdat_data,
  output logic              rdat_valid,
  output logic [DATA_W-1:0] rdat_data,
  output logic              rdat_last,
  output logic              user_start,
  output logic [ADDR_W-1:0] user_addr_in,
  output logic [LEN_W-1:0]  user_burst_len_in,
  output logic              user_w_r,
  output logic [STRB_W-1:0] user_data_strb,
  output logic [DATA_W-1:0] user_data_in,
  input  logic              user_free,
  input  logic              user_stall_w_data,
  input  logic              user_stall_r_data,
  input  logic              user_data_out_en,
  input  logic [DATA_W-1:0] user_data_out,
  input  logic [1:0]        user_status,
  output logic              busy,
  output logic              err_sticky,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(WFIFO_DEPTH + 1);

  seq_state_e        state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [LEN_W:0]    beat_q, beat_d;
  logic              stall_w_q, stall_w_d;
  logic              rdy_q, rdy_d;
  logic              rdat_valid_q, rdat_valid_d;
  logic              rdat_last_q, rdat_last_d;
  logic [DATA_W-1:0] rdat_data_q, rdat_data_d;
  logic              err_q, err_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              cmd_fire, last_beat, issued, wr_phase;

  // The master's read stall is not needed: read beats are never backpressured.
  logic unused_stall_r;
  assign unused_stall_r = user_stall_r_data;

  axi_user_seq_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .DATA_W(DATA_W)
  ) u_wfifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .push     (fifo_push),
    .push_data(wdat_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // rdy_q keeps both handshakes closed while reset is asserted.
  assign wdat_ready = rdy_q && !fifo_full;
  assign cmd_ready  = rdy_q && (state_q == ST_IDLE);
  assign fifo_push  = wdat_valid && wdat_ready;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign fifo_pop   = (state_q == ST_WBURST) && stall_w_q && !user_stall_w_data;
  assign last_beat  = (beat_q == {1'b0, cmd_q.len});
  assign issued     = (state_q == ST_ISSUE) || (state_q == ST_WBURST) ||
                      (state_q == ST_RBURST) || (state_q == ST_DRAIN);
  assign wr_phase   = (state_q == ST_ISSUE) || (state_q == ST_WBURST);

  assign busy              = (state_q != ST_IDLE);
  assign user_start        = (state_q == ST_ISSUE);
  assign user_addr_in      = issued ? ADDR_W'(cmd_q.addr) : '0;
  assign user_burst_len_in = issued ? cmd_q.len : '0;
  assign user_w_r          = issued && cmd_q.w_r;
  assign user_data_strb    = issued ? cmd_q.strb : '0;
  assign user_data_in      = wr_phase ? fifo_head : '0;
  assign rdat_valid        = rdat_valid_q;
  assign rdat_last         = rdat_last_q;
  assign rdat_data         = rdat_data_q;
  assign err_sticky        = err_q;

  // Next-state, beat counting, read capture and error flag.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    beat_d       = beat_q;
    stall_w_d    = user_stall_w_data;
    rdy_d        = 1'b1;
    rdat_valid_d = 1'b0;
    rdat_last_d  = 1'b0;
    rdat_data_d  = rdat_data_q;
    err_d        = err_clr ? 1'b0 : err_q;

    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (cmd_fire) begin
          cmd_d.addr = DEF_ADDR_W'(cmd_addr);
          cmd_d.len  = cmd_len;
          cmd_d.w_r  = cmd_w_r;
          cmd_d.strb = cmd_strb;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (user_free && (cmd_q.w_r || (fifo_count >= CNT_W'(beats_of(cmd_q.len)))))
          state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        beat_d  = '0;
        state_d = cmd_q.w_r ? ST_RBURST : ST_WBURST;
      end
      ST_WBURST: begin
        if (fifo_pop) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) state_d = ST_DRAIN;
        end
      end
      ST_RBURST: begin
        if (user_data_out_en) begin
          rdat_valid_d = 1'b1;
          rdat_data_d  = user_data_out;
          rdat_last_d  = last_beat;
          beat_d       = beat_q + 1'b1;
          if (last_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (user_free) begin
          state_d = ST_IDLE;
          if (user_status != 2'b00) err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset drops any command or read beat in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      beat_q       <= '0;
      stall_w_q    <= 1'b0;
      rdy_q        <= 1'b0;
      rdat_valid_q <= 1'b0;
      rdat_last_q  <= 1'b0;
      rdat_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      beat_q       <= beat_d;
      stall_w_q    <= stall_w_d;
      rdy_q        <= rdy_d;
      rdat_valid_q <= rdat_valid_d;
      rdat_last_q  <= rdat_last_d;
      rdat_data_q  <= rdat_data_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_user_cmd_seq.sv
// Self-checking bench for axi_user_cmd_seq: behavioural model plus directed scenarios.
module tb_axi_user_cmd_seq;

  localparam int DEPTH = 16;

  logic        aclk, aresetn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        cmd_w_r;
  logic [7:0]  cmd_strb;
  logic        wdat_valid, wdat_ready;
  logic [63:0] wdat_data;
  logic        rdat_valid, rdat_last;
  logic [63:0] rdat_data;
  logic        user_start;
  logic [31:0] user_addr_in;
  logic [3:0]  user_burst_len_in;
  logic        user_w_r;
  logic [7:0]  user_data_strb;
  logic [63:0] user_data_in;
  logic        user_free, user_stall_w_data, user_stall_r_data, user_data_out_en;
  logic [63:0] user_data_out;
  logic [1:0]  user_status;
  logic        busy, err_sticky, err_clr;

  axi_user_cmd_seq dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_w_r(cmd_w_r), .cmd_strb(cmd_strb),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
    .rdat_valid(rdat_valid), .rdat_data(rdat_data), .rdat_last(rdat_last),
    .user_start(user_start), .user_addr_in(user_addr_in),
    .user_burst_len_in(user_burst_len_in), .user_w_r(user_w_r),
    .user_data_strb(user_data_strb), .user_data_in(user_data_in),
    .user_free(user_free), .user_stall_w_data(user_stall_w_data),
    .user_stall_r_data(user_stall_r_data), .user_data_out_en(user_data_out_en),
    .user_data_out(user_data_out), .user_status(user_status),
    .busy(busy), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_ISSUE = 2, PH_WB = 3, PH_RB = 4, PH_DRAIN = 5;

  logic [63:0] m_q [$];
  int          m_ph;
  bit          m_rdy, m_stall_prev, m_rd, m_err, m_rv, m_rlast;
  logic [31:0] m_addr;
  int          m_len, m_left;
  logic [7:0]  m_strb;
  logic [63:0] m_rdata;
  bit          mp_push, mp_pop, mp_err_set, mp_issued;

  int start_cnt = 0, rv_cnt = 0, rl_cnt = 0, last_at = 0;

  always @(posedge aclk) begin
    if (!aresetn) begin
      m_q.delete();
      m_ph = PH_IDLE; m_rdy = 0; m_stall_prev = 0; m_rd = 0; m_err = 0;
      m_rv = 0; m_rlast = 0; m_addr = '0; m_len = 0; m_left = 0; m_strb = '0; m_rdata = '0;
    end else begin
      mp_push    = wdat_valid && m_rdy && (m_q.size() < DEPTH);
      mp_pop     = (m_ph == PH_WB) && m_stall_prev && !user_stall_w_data;
      mp_err_set = 0;
      m_rv = 0; m_rlast = 0;
      case (m_ph)
        PH_IDLE: if (cmd_valid && m_rdy) begin
          m_addr = cmd_addr; m_len = int'(cmd_len); m_rd = cmd_w_r; m_strb = cmd_strb;
          m_ph = PH_WAIT;
        end
        PH_WAIT: if (user_free && (m_rd || m_q.size() >= m_len + 1)) m_ph = PH_ISSUE;
        PH_ISSUE: begin m_left = m_len + 1; m_ph = m_rd ? PH_RB : PH_WB; end
        PH_WB: if (mp_pop) begin m_left--; if (m_left == 0) m_ph = PH_DRAIN; end
        PH_RB: if (user_data_out_en) begin
          m_rv = 1; m_rdata = user_data_out; m_left--;
          m_rlast = (m_left == 0);
          if (m_rlast) m_ph = PH_DRAIN;
        end
        PH_DRAIN: if (user_free) begin mp_err_set = (user_status != 2'b00); m_ph = PH_IDLE; end
        default: ;
      endcase
      if (mp_err_set) m_err = 1;
      else if (err_clr) m_err = 0;
      if (mp_pop && m_q.size() > 0) void'(m_q.pop_front());
      if (mp_push) m_q.push_back(wdat_data);
      m_stall_prev = user_stall_w_data;
      m_rdy = 1;
    end
    #2;
    if (aresetn) begin
      mp_issued = (m_ph == PH_ISSUE) || (m_ph == PH_WB) || (m_ph == PH_RB) || (m_ph == PH_DRAIN);
      chk("cmd_ready", cmd_ready, (m_ph == PH_IDLE) && m_rdy);
      chk("busy", busy, m_ph != PH_IDLE);
      chk("user_start", user_start, m_ph == PH_ISSUE);
      chk("wdat_ready", wdat_ready, m_rdy && (m_q.size() < DEPTH));
      chk("fifo_count", dut.u_wfifo.count, m_q.size());
      chk("user_addr_in", user_addr_in, mp_issued ? m_addr : 32'h0);
      chk("user_burst_len_in", user_burst_len_in, mp_issued ? m_len : 0);
      chk("user_w_r", user_w_r, mp_issued && m_rd);
      chk("user_data_strb", user_data_strb, mp_issued ? m_strb : 8'h0);
      if (m_ph == PH_ISSUE || m_ph == PH_WB) begin
        if (m_q.size() > 0) chk("user_data_in", user_data_in, m_q[0]);
      end else chk("user_data_in_idle", user_data_in, 64'h0);
      chk("rdat_valid", rdat_valid, m_rv);
      chk("rdat_last", rdat_last, m_rlast);
      chk("rdat_data", rdat_data, m_rdata);
      chk("err_sticky", err_sticky, m_err);
      if (user_start) start_cnt++;
      if (rdat_valid) rv_cnt++;
      if (rdat_last) begin rl_cnt++; last_at = rv_cnt; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_beats(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      wdat_valid = 1'b1;
      wdat_data  = base + 64'(i);
    end
    @(negedge aclk);
    wdat_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic rd, input logic [31:0] addr, input logic [3:0] len,
                          input logic [7:0] strb);
    @(negedge aclk);
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_w_r = rd; cmd_addr = addr; cmd_len = len; cmd_strb = strb;
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input int s0);
    int n = 0;
    while (start_cnt == s0 && n < 40) begin
      @(negedge aclk);
      n++;
    end
    chk("start_seen", start_cnt != s0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge aclk);
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic do_pops(input int n, input bit lit, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      user_stall_w_data = 1'b1;
      @(negedge aclk);
      if (lit) chk("wr_beat_literal", user_data_in, base + 64'(i));
      user_stall_w_data = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_wdat_ready"}, wdat_ready, 0);
    chk({tag, "_rdat_valid"}, rdat_valid, 0);
    chk({tag, "_rdat_last"}, rdat_last, 0);
    chk({tag, "_rdat_data"}, rdat_data, 0);
    chk({tag, "_user_start"}, user_start, 0);
    chk({tag, "_user_addr_in"}, user_addr_in, 0);
    chk({tag, "_user_len"}, user_burst_len_in, 0);
    chk({tag, "_user_w_r"}, user_w_r, 0);
    chk({tag, "_user_strb"}, user_data_strb, 0);
    chk({tag, "_user_data_in"}, user_data_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_sticky"}, err_sticky, 0);
    chk({tag, "_fifo_count"}, dut.u_wfifo.count, 0);
  endtask

  task automatic rd_status_cmd(input bit clr_at_drain);
    int s0;
    s0 = start_cnt;
    user_status = 2'd2;
    send_cmd(1'b1, 32'h2000_0000, 4'd0, 8'h00);
    wait_start(s0);
    user_free = 1'b0;
    @(negedge aclk);
    user_data_out_en = 1'b1; user_data_out = 64'h77;
    @(negedge aclk);
    user_data_out_en = 1'b0;
    @(negedge aclk);
    chk("held_in_drain_busy", busy, 1);
    user_free = 1'b1;
    err_clr = clr_at_drain;
    @(negedge aclk);
    err_clr = 1'b0;
    user_status = 2'd0;
    chk("err_after_drain", err_sticky, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int s0, r0, l0;
    aresetn = 1'b1;
    cmd_valid = 0; cmd_addr = '0; cmd_len = '0; cmd_w_r = 0; cmd_strb = '0;
    wdat_valid = 0; wdat_data = '0;
    user_free = 1; user_stall_w_data = 0; user_stall_r_data = 0;
    user_data_out_en = 0; user_data_out = '0; user_status = 2'd0; err_clr = 0;
    #3 aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    check_all_zero("reset");
    aresetn = 1'b1;
    @(posedge aclk); #2;
    chk("wdat_ready_after_release", wdat_ready, 1);

    // single-beat write
    push_beats(1, 64'hF8F4_F2F1);
    s0 = start_cnt;
    send_cmd(1'b0, 32'h1000_0000, 4'd0, 8'hFF);
    wait_start(s0);
    chk("t1_head_at_issue", user_data_in, 64'hF8F4_F2F1);
    chk("t1_addr", user_addr_in, 32'h1000_0000);
    chk("t1_strb", user_data_strb, 8'hFF);
    do_pops(1, 1, 64'hF8F4_F2F1);
    @(negedge aclk);
    chk("t1_fifo_empty", dut.u_wfifo.count, 0);
    wait_idle();
    chk("t1_one_start", start_cnt - s0, 1);

    // 16-beat write held back until the 16th beat arrives
    push_beats(15, 64'h0000_000A);
    s0 = start_cnt;
    send_cmd(1'b0, 32'h1000_0080, 4'd15, 8'h0F);
    repeat (6) @(negedge aclk);
    chk("t2_no_start_15", start_cnt - s0, 0);
    chk("t2_busy_waiting", busy, 1);
    push_beats(1, 64'h0000_000A + 64'd15);
    wait_start(s0);
    chk("t2_len", user_burst_len_in, 4'd15);
    do_pops(16, 1, 64'h0000_000A);
    wait_idle();
    chk("t2_fifo_empty", dut.u_wfifo.count, 0);

    // 16-beat read with a gap in the middle
    s0 = start_cnt; r0 = rv_cnt; l0 = rl_cnt;
    send_cmd(1'b1, 32'h2000_0CC0, 4'd15, 8'h00);
    wait_start(s0);
    chk("t3_w_r", user_w_r, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      if (i == 8) begin
        user_data_out_en = 1'b0;
        @(negedge aclk);
      end
      user_data_out_en = 1'b1;
      user_data_out = 64'hCAFE_0000_0000_0000 + 64'(i);
    end
    @(negedge aclk);
    user_data_out_en = 1'b0;
    @(negedge aclk);
    user_data_out_en = 1'b1;
    user_data_out = 64'h1234;
    @(negedge aclk);
    user_data_out_en = 1'b0;
    wait_idle();
    chk("t3_rv_count", rv_cnt - r0, 16);
    chk("t3_last_count", rl_cnt - l0, 1);
    chk("t3_last_on_16", last_at - r0, 16);
    chk("t3_final_data", rdat_data, 64'hCAFE_0000_0000_000F);

    // error status, set-wins-over-clear, then clear alone
    rd_status_cmd(1'b0);
    rd_status_cmd(1'b1);
    user_status = 2'd2;
    err_clr = 1'b1;
    @(negedge aclk);
    err_clr = 1'b0;
    user_status = 2'd0;
    chk("t4_err_cleared", err_sticky, 0);

    // full FIFO, ignored push, push+pop in the same cycle
    push_beats(16, 64'h100);
    @(negedge aclk);
    wdat_valid = 1'b1; wdat_data = 64'hDEAD;
    @(negedge aclk);
    chk("t6_ready_when_full", wdat_ready, 0);
    chk("t6_count_full", dut.u_wfifo.count, 16);
    wdat_valid = 1'b0;
    s0 = start_cnt;
    send_cmd(1'b0, 32'h3000_0000, 4'd15, 8'h33);
    wait_start(s0);
    do_pops(1, 1, 64'h100);
    @(negedge aclk);
    user_stall_w_data = 1'b1;
    @(negedge aclk);
    chk("t6_count_before_pp", dut.u_wfifo.count, 15);
    user_stall_w_data = 1'b0;
    wdat_valid = 1'b1; wdat_data = 64'hBEEF;
    @(negedge aclk);
    wdat_valid = 1'b0;
    chk("t6_count_after_pp", dut.u_wfifo.count, 15);
    do_pops(14, 0, 64'h0);
    wait_idle();
    chk("t6_leftover", dut.u_wfifo.count, 1);

    // reset in the middle of a write burst
    push_beats(16, 64'h200);
    s0 = start_cnt;
    send_cmd(1'b0, 32'h4000_0000, 4'd15, 8'hFF);
    wait_start(s0);
    do_pops(5, 0, 64'h0);
    @(negedge aclk);
    #3 aresetn = 1'b0;
    #1 check_all_zero("midrst");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #2;
    chk("t5_wdat_ready_release", wdat_ready, 1);
    chk("t5_cmd_ready_release", cmd_ready, 1);
    push_beats(1, 64'h5555);
    s0 = start_cnt;
    send_cmd(1'b0, 32'h5000_0000, 4'd0, 8'h01);
    wait_start(s0);
    chk("t5_head", user_data_in, 64'h5555);
    do_pops(1, 1, 64'h5555);
    wait_idle();
    chk("t5_one_start", start_cnt - s0, 1);
    chk("t5_fifo_empty", dut.u_wfifo.count, 0);

    repeat (3) @(negedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
